// File: rtl/idecode_if.sv
// idecode_if: fetch/writeback/hazard inputs and ID/EX outputs of the decode stage.
// Bit numbering is big-endian (bit 0 is the MSB) throughout.
interface idecode_if;
    logic [0:31] ir_in;
    logic [0:31] pc_in;
    logic        wb_we;
    logic [0:4]  wb_addr;
    logic [0:31] wb_data;
    logic        ex_memread;
    logic        ex_regwrite;
    logic [0:4]  ex_dest;
    logic        mem_regwrite;
    logic [0:4]  mem_dest;
    logic        stall;
    logic        br_taken;
    logic [0:31] br_target;
    logic        valid_out;
    logic [0:31] pc_out;
    logic [0:31] rs_data;
    logic [0:31] rt_data;
    logic [0:31] imm_ext;
    logic [0:4]  dest;
    logic [0:5]  funct;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic        illegal;

    modport master (
        output ir_in, pc_in, wb_we, wb_addr, wb_data,
               ex_memread, ex_regwrite, ex_dest, mem_regwrite, mem_dest,
        input  stall, br_taken, br_target, valid_out, pc_out, rs_data, rt_data,
               imm_ext, dest, funct, reg_write, mem_read, mem_write, alu_src, illegal
    );

    modport slave (
        input  ir_in, pc_in, wb_we, wb_addr, wb_data,
               ex_memread, ex_regwrite, ex_dest, mem_regwrite, mem_dest,
        output stall, br_taken, br_target, valid_out, pc_out, rs_data, rt_data,
               imm_ext, dest, funct, reg_write, mem_read, mem_write, alu_src, illegal
    );
endinterface

// File: rtl/idecode.sv
// idecode: IF/ID latch, 32x32 register file, decode, in-decode branch resolution and hazard stall.
// Define DECODE_BYPASS_EN to forward same-cycle writeback data to register reads.
module idecode (
    input  logic     clock,
    input  logic     reset_n,
    idecode_if.slave bus
);
    localparam logic [0:5] OP_RTYPE = 6'h00;
    localparam logic [0:5] OP_J     = 6'h02;
    localparam logic [0:5] OP_BEQ   = 6'h04;
    localparam logic [0:5] OP_BNE   = 6'h05;
    localparam logic [0:5] OP_ADDI  = 6'h08;
    localparam logic [0:5] OP_LW    = 6'h23;
    localparam logic [0:5] OP_SW    = 6'h2B;

    typedef struct packed {
        logic        valid;
        logic [0:31] pc;
        logic [0:31] rs_data;
        logic [0:31] rt_data;
        logic [0:31] imm;
        logic [0:4]  dest;
        logic [0:5]  funct;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        alu_src;
        logic        illegal;
    } idex_t;

    logic [0:31] ir_q, ir_d, pc_q, pc_d;
    logic        if_vld_q, if_vld_d;
    logic [0:31] rf_q [32];
    logic [0:31] rf_d [32];
    idex_t       idex_q, idex_d;

    logic [0:5]  opcode;
    logic [0:4]  rs, rt, rd;
    logic [0:15] imm;
    logic [0:25] jidx;
    logic [0:31] rs_val, rt_val, imm_ext, pc4, target;
    logic [0:4]  dec_dest;
    logic        dec_rw, dec_mr, dec_mw, dec_as, dec_ill;
    logic        uses_rt, is_br, is_j;
    logic        load_use, br_hz, wb_hz, stall, taken;

    assign opcode  = ir_q[0:5];
    assign rs      = ir_q[6:10];
    assign rt      = ir_q[11:15];
    assign rd      = ir_q[16:20];
    assign imm     = ir_q[16:31];
    assign jidx    = ir_q[6:31];
    assign imm_ext = {{16{imm[0]}}, imm};
    assign pc4     = pc_q + 32'd4;

    always_comb begin
        rs_val = (rs == 5'd0) ? 32'd0 : rf_q[rs];
        rt_val = (rt == 5'd0) ? 32'd0 : rf_q[rt];
`ifdef DECODE_BYPASS_EN
        if (bus.wb_we && bus.wb_addr != 5'd0 && bus.wb_addr == rs) rs_val = bus.wb_data;
        if (bus.wb_we && bus.wb_addr != 5'd0 && bus.wb_addr == rt) rt_val = bus.wb_data;
`endif
    end

    always_comb begin
        dec_rw   = 1'b0;
        dec_mr   = 1'b0;
        dec_mw   = 1'b0;
        dec_as   = 1'b0;
        dec_ill  = 1'b0;
        dec_dest = 5'd0;
        uses_rt  = 1'b0;
        is_br    = 1'b0;
        is_j     = 1'b0;
        case (opcode)
            OP_RTYPE: begin dec_rw = 1'b1; dec_dest = rd; uses_rt = 1'b1; end
            OP_ADDI:  begin dec_rw = 1'b1; dec_as = 1'b1; dec_dest = rt; end
            OP_LW:    begin dec_rw = 1'b1; dec_mr = 1'b1; dec_as = 1'b1; dec_dest = rt; end
            OP_SW:    begin dec_mw = 1'b1; dec_as = 1'b1; uses_rt = 1'b1; end
            OP_BEQ, OP_BNE: begin is_br = 1'b1; uses_rt = 1'b1; end
            OP_J:     is_j = 1'b1;
            default:  dec_ill = 1'b1;
        endcase
    end

    // Branches compare in decode, so any in-flight producer of an operand must drain first.
    assign load_use = bus.ex_memread && bus.ex_dest != 5'd0 &&
                      (bus.ex_dest == rs || (uses_rt && bus.ex_dest == rt));
    assign br_hz    = is_br &&
                      ((bus.ex_regwrite && bus.ex_dest != 5'd0 &&
                        (bus.ex_dest == rs || bus.ex_dest == rt)) ||
                       (bus.mem_regwrite && bus.mem_dest != 5'd0 &&
                        (bus.mem_dest == rs || bus.mem_dest == rt)));
`ifdef DECODE_BYPASS_EN
    assign wb_hz    = 1'b0;
`else
    assign wb_hz    = bus.wb_we && bus.wb_addr != 5'd0 &&
                      (bus.wb_addr == rs || bus.wb_addr == rt);
`endif
    assign stall    = if_vld_q && (load_use || br_hz || wb_hz);

    always_comb begin
        taken  = if_vld_q && !stall &&
                 (is_j || (opcode == OP_BEQ && rs_val == rt_val) ||
                          (opcode == OP_BNE && rs_val != rt_val));
        target = 32'd0;
        if (taken) target = is_j ? {pc4[0:3], jidx, 2'b00} : pc4 + {imm_ext[2:31], 2'b00};
    end

    always_comb begin
        ir_d     = ir_q;
        pc_d     = pc_q;
        if_vld_d = if_vld_q;
        if (!stall) begin
            ir_d     = bus.ir_in;
            pc_d     = bus.pc_in;
            if_vld_d = 1'b1;
        end
        rf_d = rf_q;
        if (bus.wb_we && bus.wb_addr != 5'd0) rf_d[bus.wb_addr] = bus.wb_data;
    end

    // A stalled or empty slot issues an all-zero bubble.
    always_comb begin
        idex_d = '0;
        if (if_vld_q && !stall) begin
            idex_d.valid     = 1'b1;
            idex_d.pc        = pc_q;
            idex_d.rs_data   = rs_val;
            idex_d.rt_data   = rt_val;
            idex_d.imm       = imm_ext;
            idex_d.dest      = dec_dest;
            idex_d.funct     = ir_q[26:31];
            idex_d.reg_write = dec_rw;
            idex_d.mem_read  = dec_mr;
            idex_d.mem_write = dec_mw;
            idex_d.alu_src   = dec_as;
            idex_d.illegal   = dec_ill;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ir_q     <= '0;
            pc_q     <= '0;
            if_vld_q <= 1'b0;
            idex_q   <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            ir_q     <= ir_d;
            pc_q     <= pc_d;
            if_vld_q <= if_vld_d;
            idex_q   <= idex_d;
            for (int i = 0; i < 32; i++) rf_q[i] <= rf_d[i];
        end
    end

    assign bus.stall     = stall;
    assign bus.br_taken  = taken;
    assign bus.br_target = target;
    assign bus.valid_out = idex_q.valid;
    assign bus.pc_out    = idex_q.pc;
    assign bus.rs_data   = idex_q.rs_data;
    assign bus.rt_data   = idex_q.rt_data;
    assign bus.imm_ext   = idex_q.imm;
    assign bus.dest      = idex_q.dest;
    assign bus.funct     = idex_q.funct;
    assign bus.reg_write = idex_q.reg_write;
    assign bus.mem_read  = idex_q.mem_read;
    assign bus.mem_write = idex_q.mem_write;
    assign bus.alu_src   = idex_q.alu_src;
    assign bus.illegal   = idex_q.illegal;
endmodule

// File: doc/idecode.md
# idecode

Instruction-decode stage sitting directly downstream of instruction fetch. It latches the fetched instruction word and its PC, reads the 32x32 register file, sign-extends immediates and produces ID/EX control. It resolves BEQ/BNE/J in decode, driving the fetch stage's PC-load inputs, and detects load-use and branch-operand hazards, driving the fetch stall.

## Interface
- No parameters. Bit numbering is big-endian: bit 0 is the MSB.
- clock  in  1  system clock; fetch updates on negedge, this block updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- ir_in  in  [0:31]  instruction from fetch
- pc_in  in  [0:31]  PC of ir_in
- wb_we  in  1  writeback register write enable
- wb_addr  in  [0:4]  writeback destination
- wb_data  in  [0:31]  writeback data
- ex_memread  in  1  instruction in EX is LW
- ex_regwrite  in  1  instruction in EX writes a register
- ex_dest  in  [0:4]  EX destination register
- mem_regwrite  in  1  instruction in MEM writes a register
- mem_dest  in  [0:4]  MEM destination register
- stall  out  1  to fetch stall; combinational
- br_taken  out  1  to fetch pc_pulse; combinational
- br_target  out  [0:31]  to fetch PC input; combinational
- valid_out  out  1  ID/EX slot holds a real instruction
- pc_out, rs_data, rt_data, imm_ext  out  [0:31]  registered ID/EX data
- dest  out  [0:4]  rd for R-type; rt for ADDI/LW
- funct  out  [0:5]  ir[26:31]
- reg_write, mem_read, mem_write, alu_src  out  1 each  registered control
- illegal  out  1  registered; unknown opcode was decoded

## Operation
- Fields: opcode ir[0:5], rs ir[6:10], rt ir[11:15], rd ir[16:20], funct ir[26:31], imm ir[16:31], jump index ir[6:31].
- IF/ID latch (ir, pc, valid) loads on each posedge when stall=0 and holds when stall=1. Reset clears valid.
- Decode table:
  - 0x00 R-type: reg_write, dest=rd.
  - 0x08 ADDI: reg_write, alu_src, dest=rt.
  - 0x23 LW: reg_write, mem_read, alu_src, dest=rt.
  - 0x2B SW: mem_write, alu_src.
  - 0x04 BEQ, 0x05 BNE, 0x02 J: no writes.
  - Any other opcode: bubble controls with illegal=1.
- imm_ext = sign-extension of imm to 32 bits.
- Register file: 32 x 32-bit. Write on posedge when wb_we=1 and wb_addr!=0. r0 always reads 0. Reset clears all entries.
- Hazards, evaluated only when the latch is valid:
  - Load-use: stall=1 if ex_memread and ex_dest!=0 and ex_dest equals rs, or equals rt for R-type/SW/BEQ/BNE.
  - Branch operand: stall=1 for BEQ/BNE if ex_regwrite or mem_regwrite targets a nonzero rs or rt.
- While stalled, the ID/EX register loads a bubble at posedge: valid_out=0, all control bits=0, illegal=0.
- Branch: br_taken = valid & !stall & (J, or BEQ with rs_val==rt_val, or BNE with rs_val!=rt_val).
  - BEQ/BNE target = pc+4 + (imm_ext<<2), modulo 2^32.
  - J target = {(pc+4)[0:3], index, 2'b00}.
  - br_target = 0 when br_taken=0.
- There is no delay slot and no squash. Fetch samples br_taken at the mid-cycle negedge, so the next captured word is the target.

## Timing
- Word captured at posedge N appears on the ID/EX outputs after posedge N+1.
- stall, br_taken and br_target are valid during cycle N, settled before the negedge.
- Reset values: every registered output is 0; stall, br_taken and br_target are 0 while the latch is invalid.
- Reset asserted mid-stall clears the latch, so stall drops immediately.
- Writeback to a register read in the same cycle: see Configuration.
- Simultaneous stall and branch: stall wins, br_taken=0.

## Configuration
- DECODE_BYPASS_EN defined: when wb_we=1 and wb_addr (nonzero) matches rs or rt, reads return wb_data in the same cycle. This covers both operand outputs and branch compare.
- DECODE_BYPASS_EN undefined: reads return the pre-write value. Hazard logic additionally stalls on a wb_we match with a nonzero rs/rt.

## Test plan
- Reset_n low mid-run, with valid held, then release → all outputs 0; the first ir_in=0x20010005 (ADDI r1,r0,5) gives dest=1, imm_ext=5, reg_write=1, alu_src=1 one posedge later.
- LW r2 in EX (ex_memread=1, ex_dest=2), ID holds ADD r3,r2,r1 → stall=1 for one cycle and one bubble; then ADD issues with valid_out=1.
- r4=r5=7, BEQ r4,r5,-2 at pc 0x40 → br_taken=1, br_target=0x3C; the next captured pc_in is 0x3C.
- J index 0x10 at pc 0x80 → br_target=0x40; BNE with equal operands → br_taken=0.
- wb_we=1, wb_addr=6, wb_data=0xDEADBEEF while ID reads r6 → rs_data=0xDEADBEEF with bypass; without bypass, stall=1 then 0xDEADBEEF on the next cycle.
- Opcode 0x3F → illegal=1, all writes 0; wb write to r0 → r0 still reads 0.
